// File: rtl/jet_pkg.sv
// jet_pkg: shared field width, cone constants, tower record and builder FSM states.
package jet_pkg;

  parameter int W          = 10;
  parameter int RADIUS2    = 100;
  parameter int PHI_PERIOD = 62;

  typedef struct packed {
    logic [W-1:0] eta;
    logic [W-1:0] phi;
    logic [W-1:0] et;
    logic [W-1:0] e;
  } tower_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/jet_dr2.sv
// jet_dr2: combinational deltaR^2 between a seed and a tower, phi wrapped on PHI_PERIOD.
// Shared with the seed selector, so it carries no state and no handshake.
module jet_dr2 #(
  parameter int W          = jet_pkg::W,
  parameter int PHI_PERIOD = jet_pkg::PHI_PERIOD
) (
  input  logic [W-1:0] seed_eta_i,
  input  logic [W-1:0] seed_phi_i,
  input  logic [W-1:0] twr_eta_i,
  input  logic [W-1:0] twr_phi_i,
  output logic [2*W:0] dr2_o
);

  logic [W-1:0]   deta;
  logic [W-1:0]   dphi_raw;
  logic [W-1:0]   dphi;
  logic [2*W-1:0] sq_eta;
  logic [2*W-1:0] sq_phi;

  always_comb begin
    deta     = (seed_eta_i >= twr_eta_i) ? (seed_eta_i - twr_eta_i) : (twr_eta_i - seed_eta_i);
    dphi_raw = (seed_phi_i >= twr_phi_i) ? (seed_phi_i - twr_phi_i) : (twr_phi_i - seed_phi_i);
    // The short way round the phi ring is the true angular distance.
    dphi     = (dphi_raw > W'(PHI_PERIOD / 2)) ? (W'(PHI_PERIOD) - dphi_raw) : dphi_raw;
    sq_eta   = {{W{1'b0}}, deta} * {{W{1'b0}}, deta};
    sq_phi   = {{W{1'b0}}, dphi} * {{W{1'b0}}, dphi};
    dr2_o    = {1'b0, sq_eta} + {1'b0, sq_phi};
  end

endmodule

// File: rtl/jet_builder.sv
// jet_builder: sums every tower inside a RADIUS2 cone around each accepted seed.
// Optional JET_BUILDER_EXCLUSIVE_EN: a tower joins at most one jet per frame.
module jet_builder #(
  parameter int  W          = jet_pkg::W,
  parameter int  MAX_TOWERS = 1024,
  parameter int  RADIUS2    = jet_pkg::RADIUS2,
  parameter int  PHI_PERIOD = jet_pkg::PHI_PERIOD,
  localparam int AW         = $clog2(MAX_TOWERS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     numtowers,
  input  logic            frame_start,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic [W-1:0]    seed_eta,
  input  logic [W-1:0]    seed_phi,
  input  logic [W-1:0]    seed_et,
  input  logic [W-1:0]    seed_e,
  output logic [AW-1:0]   twr_addr,
  input  logic [W-1:0]    twr_eta,
  input  logic [W-1:0]    twr_phi,
  input  logic [W-1:0]    twr_et,
  input  logic [W-1:0]    twr_e,
  output logic            jet_valid,
  input  logic            jet_ready,
  output logic [W-1:0]    jet_eta,
  output logic [W-1:0]    jet_phi,
  output logic [2*W-1:0]  jet_et,
  output logic [2*W-1:0]  jet_e,
  output logic [10:0]     jet_ntowers,
  output jet_pkg::state_e dbg_state_o,
  output logic [W-1:0]    dbg_seed_e_o
);

  import jet_pkg::*;

  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both 1; the producer holds its payload stable while
  // valid is 1 and ready is 0, and valid never depends on ready.

  state_e         state_q, state_d;
  logic           rdy_en_q;
  logic [W-1:0]   seed_eta_q, seed_eta_d;
  logic [W-1:0]   seed_phi_q, seed_phi_d;
  logic [W-1:0]   seed_e_q, seed_e_d;
  logic [10:0]    ntw_q, ntw_d;
  logic [10:0]    idx_q, idx_d;
  logic           pend_q, pend_d;
  logic [2*W-1:0] et_sum_q, et_sum_d;
  logic [2*W-1:0] e_sum_q, e_sum_d;
  logic [10:0]    cnt_q, cnt_d;

  logic           start;
  logic           abort;
  logic           last_addr;
  logic           in_cone;
  logic           twr_used;
  logic           take;
  logic [10:0]    ntw_clamp;
  logic [2*W:0]   dr2;

  jet_dr2 #(
    .W          (W),
    .PHI_PERIOD (PHI_PERIOD)
  ) u_dr2 (
    .seed_eta_i (seed_eta_q),
    .seed_phi_i (seed_phi_q),
    .twr_eta_i  (twr_eta),
    .twr_phi_i  (twr_phi),
    .dr2_o      (dr2)
  );

  assign seed_ready   = (state_q == ST_IDLE) && rdy_en_q;
  assign jet_valid    = (state_q == ST_EMIT);
  assign twr_addr     = idx_q[AW-1:0];
  assign jet_eta      = seed_eta_q;
  assign jet_phi      = seed_phi_q;
  assign jet_et       = et_sum_q;
  assign jet_e        = e_sum_q;
  assign jet_ntowers  = cnt_q;
  assign dbg_state_o  = state_q;
  assign dbg_seed_e_o = seed_e_q;

  always_comb begin
    start     = seed_valid && seed_ready && (seed_et != '0);
    abort     = frame_start && (state_q != ST_IDLE);
    last_addr = ((idx_q + 11'd1) == ntw_q);
    ntw_clamp = (numtowers > 11'(MAX_TOWERS)) ? 11'(MAX_TOWERS) : numtowers;
    in_cone   = (dr2 < (2*W+1)'(RADIUS2));
    // pend_q marks that the tower bus carries data for last cycle's address.
    take      = pend_q && in_cone && (twr_et != '0) && !twr_used;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (ntw_q == '0)    state_d = ST_EMIT;
        else if (last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        if (jet_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    seed_eta_d = seed_eta_q;
    seed_phi_d = seed_phi_q;
    seed_e_d   = seed_e_q;
    ntw_d      = ntw_q;
    idx_d      = idx_q;
    et_sum_d   = et_sum_q;
    e_sum_d    = e_sum_q;
    cnt_d      = cnt_q;
    pend_d     = (state_q == ST_SCAN) && (ntw_q != '0) && !abort;
    if (start) begin
      seed_eta_d = seed_eta;
      seed_phi_d = seed_phi;
      seed_e_d   = seed_e;
      ntw_d      = ntw_clamp;
      idx_d      = '0;
      et_sum_d   = '0;
      e_sum_d    = '0;
      cnt_d      = '0;
    end else if ((state_q == ST_SCAN) && (ntw_q != '0) && !last_addr) begin
      idx_d = idx_q + 11'd1;
    end
    if (take) begin
      et_sum_d = et_sum_q + {{W{1'b0}}, twr_et};
      e_sum_d  = e_sum_q + {{W{1'b0}}, twr_e};
      cnt_d    = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdy_en_q   <= 1'b0;
      seed_eta_q <= '0;
      seed_phi_q <= '0;
      seed_e_q   <= '0;
      ntw_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      et_sum_q   <= '0;
      e_sum_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      seed_eta_q <= seed_eta_d;
      seed_phi_q <= seed_phi_d;
      seed_e_q   <= seed_e_d;
      ntw_q      <= ntw_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      et_sum_q   <= et_sum_d;
      e_sum_q    <= e_sum_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef JET_BUILDER_EXCLUSIVE_EN
  logic [MAX_TOWERS-1:0] used_q;
  logic [AW-1:0]         pend_idx_q;

  assign twr_used = used_q[pend_idx_q];

  // A new frame releases every tower for the next set of seeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q     <= '0;
      pend_idx_q <= '0;
    end else begin
      pend_idx_q <= idx_q[AW-1:0];
      if (frame_start)  used_q <= '0;
      else if (take)    used_q[pend_idx_q] <= 1'b1;
    end
  end
`else
  assign twr_used = 1'b0;
`endif

endmodule

// File: tb/tb_jet_builder.sv
// tb_jet_builder: directed and random scenarios for jet_builder, checked against a
// cone-sum model feeding an expected-jet queue.
`timescale 1ns/1ps
module tb_jet_builder;
  import jet_pkg::*;

  localparam int EW = 71;

  logic        clk, rst;
  logic [10:0] numtowers;
  logic        frame_start, seed_valid, seed_ready;
  logic [9:0]  seed_eta, seed_phi, seed_et, seed_e;
  logic [9:0]  twr_addr;
  logic [9:0]  twr_eta, twr_phi, twr_et, twr_e;
  logic        jet_valid, jet_ready;
  logic [9:0]  jet_eta, jet_phi;
  logic [19:0] jet_et, jet_e;
  logic [10:0] jet_ntowers;
  state_e      dbg_state;
  logic [9:0]  dbg_seed_e;

  tower_t      mem [0:1023];
  logic        used_m [0:1023];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_x;
  int          n_cmp, n_fail;

  jet_builder dut (
    .clk(clk), .rst(rst), .numtowers(numtowers), .frame_start(frame_start),
    .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_eta(seed_eta), .seed_phi(seed_phi), .seed_et(seed_et), .seed_e(seed_e),
    .twr_addr(twr_addr),
    .twr_eta(twr_eta), .twr_phi(twr_phi), .twr_et(twr_et), .twr_e(twr_e),
    .jet_valid(jet_valid), .jet_ready(jet_ready),
    .jet_eta(jet_eta), .jet_phi(jet_phi), .jet_et(jet_et), .jet_e(jet_e),
    .jet_ntowers(jet_ntowers), .dbg_state_o(dbg_state), .dbg_seed_e_o(dbg_seed_e)
  );

  // ---------------- clock / tower memory ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    twr_eta <= mem[twr_addr].eta;
    twr_phi <= mem[twr_addr].phi;
    twr_et  <= mem[twr_addr].et;
    twr_e   <= mem[twr_addr].e;
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_jet(input logic [9:0] s_eta, input logic [9:0] s_phi,
                                              input int ntw);
    int de, dp, d2, n;
    logic [19:0] xet, xe;
    xet = '0; xe = '0; n = 0;
    for (int i = 0; i < ntw; i++) begin
      de = int'(s_eta) - int'(mem[i].eta);
      if (de < 0) de = -de;
      dp = int'(s_phi) - int'(mem[i].phi);
      if (dp < 0) dp = -dp;
      if (dp > 31) dp = 62 - dp;
      d2 = de * de + dp * dp;
      if (d2 < 100 && mem[i].et != 0 && !used_m[i]) begin
        xet = xet + {10'd0, mem[i].et};
        xe  = xe + {10'd0, mem[i].e};
        n++;
`ifdef JET_BUILDER_EXCLUSIVE_EN
        used_m[i] = 1'b1;
`endif
      end
    end
    return {s_eta, s_phi, xet, xe, 11'(n)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && jet_valid && jet_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_jet: jet_et=%0d ntowers=%0d, required no jet", jet_et, jet_ntowers);
      end else begin
        mon_x = exp_q.pop_front();
        n_cmp++;
        if (jet_eta !== mon_x[70:61]) begin n_fail++; $display("FAIL jet_eta: got %0d required %0d", jet_eta, mon_x[70:61]); end
        n_cmp++;
        if (jet_phi !== mon_x[60:51]) begin n_fail++; $display("FAIL jet_phi: got %0d required %0d", jet_phi, mon_x[60:51]); end
        n_cmp++;
        if (jet_et !== mon_x[50:31]) begin n_fail++; $display("FAIL jet_et: got %0d required %0d", jet_et, mon_x[50:31]); end
        n_cmp++;
        if (jet_e !== mon_x[30:11]) begin n_fail++; $display("FAIL jet_e: got %0d required %0d", jet_e, mon_x[30:11]); end
        n_cmp++;
        if (jet_ntowers !== mon_x[10:0]) begin n_fail++; $display("FAIL jet_ntowers: got %0d required %0d", jet_ntowers, mon_x[10:0]); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_twr(input int i, input int eta, input int phi, input int et, input int e);
    mem[i] = '{eta: 10'(eta), phi: 10'(phi), et: 10'(et), e: 10'(e)};
  endtask

  task automatic load_basic();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    set_twr(0, 10, 10, 50, 60);
    set_twr(1, 15, 12, 20, 25);
    set_twr(2, 30, 10, 40, 45);
  endtask

  task automatic clear_used();
    for (int i = 0; i < 1024; i++) used_m[i] = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    clear_used();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. early in cycle 1.
  task automatic send_seed(input int eta, input int phi, input int et, input int e,
                           input int ntw, input bit push);
    int t;
    @(negedge clk);
    seed_eta = 10'(eta); seed_phi = 10'(phi); seed_et = 10'(et); seed_e = 10'(e);
    numtowers = 11'(ntw);
    seed_valid = 1'b1;
    t = 0;
    while (!seed_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_accept: seed_ready=%b required 1 within 200 cycles", seed_ready);
    end else if (push && et != 0) begin
      exp_q.push_back(model_jet(10'(eta), 10'(phi), ntw));
    end
    @(posedge clk);
    #1;
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int t = 0;
    while (jet_valid !== 1'b1 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (jet_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid_timeout: jet_valid=%b required 1 within %0d cycles", name, jet_valid, budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d jets outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (seed_ready !== 1'b0 || jet_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: seed_ready=%b jet_valid=%b required 0 0", seed_ready, jet_valid);
    end
    n_cmp++;
    if (twr_addr !== '0 || {jet_eta, jet_phi, jet_et, jet_e, jet_ntowers} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: twr_addr=%0d jet_et=%0d jet_ntowers=%0d required 0", twr_addr, jet_et, jet_ntowers);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (seed_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: seed_ready=%b required 0", seed_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (seed_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_edge: seed_ready=%b required 1", seed_ready);
    end
  endtask

  task automatic test_basic();
    load_basic();
    frame_pulse();
    send_seed(10, 10, 50, 60, 3, 1'b1);
    n_cmp++;
    if (twr_addr !== 10'd0 || dbg_state !== ST_SCAN) begin
      n_fail++; $display("FAIL basic_cycle1: twr_addr=%0d state=%0d required 0 %0d", twr_addr, dbg_state, ST_SCAN);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (twr_addr !== 10'd1) begin
      n_fail++; $display("FAIL basic_cycle2: twr_addr=%0d required 1", twr_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (jet_valid !== 1'b0 || dbg_state !== ST_DRAIN) begin
      n_fail++; $display("FAIL basic_cycle4: jet_valid=%b state=%0d required 0 %0d", jet_valid, dbg_state, ST_DRAIN);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (jet_valid !== 1'b1 || jet_et !== 20'd70 || jet_e !== 20'd85 || jet_ntowers !== 11'd2) begin
      n_fail++;
      $display("FAIL basic_cycle5: valid=%b et=%0d e=%0d n=%0d required 1 70 85 2", jet_valid, jet_et, jet_e, jet_ntowers);
    end
    wait_drain(50);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    set_twr(0, 20, 60, 8, 3);
    set_twr(1, 20, 30, 5, 2);
    set_twr(2, 29, 1, 7, 4);
    set_twr(3, 30, 1, 9, 6);
    set_twr(4, 20, 1, 0, 9);
    frame_pulse();
    send_seed(20, 1, 30, 7, 5, 1'b1);
    wait_valid("wrap", 20);
    n_cmp++;
    if (jet_et !== 20'd15 || jet_e !== 20'd7 || jet_ntowers !== 11'd2) begin
      n_fail++; $display("FAIL wrap_sum: et=%0d e=%0d n=%0d required 15 7 2", jet_et, jet_e, jet_ntowers);
    end
    wait_drain(50);
  endtask

  task automatic test_zero_et();
    logic [9:0] addr0;
    load_basic();
    addr0 = twr_addr;
    send_seed(10, 10, 0, 5, 3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (seed_ready !== 1'b1 || twr_addr !== addr0 || jet_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_et: ready=%b addr=%0d valid=%b required 1 %0d 0", seed_ready, twr_addr, jet_valid, addr0);
      end
    end
  endtask

  task automatic test_empty();
    send_seed(5, 5, 9, 1, 0, 1'b1);
    n_cmp++;
    if (jet_valid !== 1'b0 || dbg_state !== ST_SCAN) begin
      n_fail++; $display("FAIL empty_cycle1: valid=%b state=%0d required 0 %0d", jet_valid, dbg_state, ST_SCAN);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (jet_valid !== 1'b1 || jet_et !== '0 || jet_ntowers !== '0) begin
      n_fail++; $display("FAIL empty_cycle2: valid=%b et=%0d n=%0d required 1 0 0", jet_valid, jet_et, jet_ntowers);
    end
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] cap;
    load_basic();
    frame_pulse();
    jet_ready = 1'b0;
    send_seed(12, 11, 40, 3, 3, 1'b1);
    wait_valid("bp", 20);
    cap = {jet_eta, jet_phi, jet_et, jet_e, jet_ntowers};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({jet_eta, jet_phi, jet_et, jet_e, jet_ntowers} !== cap || jet_valid !== 1'b1 || seed_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: et=%0d n=%0d valid=%b ready=%b required %0d %0d 1 0",
                 jet_et, jet_ntowers, jet_valid, seed_ready, cap[50:31], cap[10:0]);
      end
    end
    @(posedge clk); #1;
    jet_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (jet_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL bp_release: valid=%b state=%0d required 0 %0d", jet_valid, dbg_state, ST_IDLE);
    end
    wait_drain(20);
  endtask

  task automatic test_back_to_back();
    load_basic();
    frame_pulse();
    send_seed(10, 10, 50, 60, 3, 1'b1);
    send_seed(10, 10, 50, 60, 3, 1'b1);
    wait_valid("b2b", 20);
    n_cmp++;
`ifdef JET_BUILDER_EXCLUSIVE_EN
    if (jet_ntowers !== 11'd0) begin
      n_fail++; $display("FAIL b2b_second: ntowers=%0d required 0", jet_ntowers);
    end
`else
    if (jet_ntowers !== 11'd2) begin
      n_fail++; $display("FAIL b2b_second: ntowers=%0d required 2", jet_ntowers);
    end
`endif
    wait_drain(50);
    frame_pulse();
    send_seed(10, 10, 50, 60, 3, 1'b1);
    wait_valid("b2b_frame", 20);
    n_cmp++;
    if (jet_ntowers !== 11'd2 || jet_et !== 20'd70) begin
      n_fail++; $display("FAIL b2b_new_frame: ntowers=%0d et=%0d required 2 70", jet_ntowers, jet_et);
    end
    wait_drain(50);
  endtask

  task automatic test_abort();
    load_basic();
    frame_pulse();
    send_seed(10, 10, 50, 60, 8, 1'b0);
    @(negedge clk);
    frame_start = 1'b1;
    clear_used();
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== ST_IDLE || jet_valid !== 1'b0 || seed_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort: state=%0d valid=%b ready=%b required %0d 0 1", dbg_state, jet_valid, seed_ready, ST_IDLE);
    end
    repeat (15) @(posedge clk);
    send_seed(15, 12, 20, 2, 3, 1'b1);
    wait_drain(50);
  endtask

  task automatic test_reset_mid();
    load_basic();
    frame_pulse();
    send_seed(10, 10, 50, 60, 8, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (twr_addr !== '0 || jet_valid !== 1'b0 || seed_ready !== 1'b0 ||
        {jet_eta, jet_phi, jet_et, jet_e, jet_ntowers} !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid: addr=%0d valid=%b ready=%b eta=%0d state=%0d required 0 0 0 0 %0d",
               twr_addr, jet_valid, seed_ready, jet_eta, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_used();
    repeat (12) @(posedge clk);
    send_seed(10, 10, 50, 60, 3, 1'b1);
    wait_drain(50);
  endtask

  task automatic test_random();
    int idx, ntw;
    for (int i = 0; i < 16; i++)
      set_twr(i, $urandom_range(0, 40), $urandom_range(0, 61), $urandom_range(0, 60), $urandom_range(0, 900));
    frame_pulse();
    for (int s = 0; s < 10; s++) begin
      idx = $urandom_range(0, 15);
      ntw = $urandom_range(0, 16);
      send_seed(int'(mem[idx].eta), int'(mem[idx].phi), $urandom_range(1, 63), $urandom_range(0, 500), ntw, 1'b1);
    end
    wait_drain(200);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; frame_start = 1'b0; seed_valid = 1'b0; jet_ready = 1'b1;
    numtowers = '0; seed_eta = '0; seed_phi = '0; seed_et = '0; seed_e = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear_used();
    test_reset();
    test_basic();
    test_wrap();
    test_zero_et();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jet_builder.md
JET_BUILDER -- requirements
Module: jet_builder

Interface
REQ-001 Parameter W, default 10: width of every eta/phi/et/e field.
REQ-002 Parameter MAX_TOWERS, default 1024: tower memory depth; address width is clog2(MAX_TOWERS).
REQ-003 Parameter RADIUS2, default 100: cone limit on deltaR squared.
REQ-004 Parameter PHI_PERIOD, default 62: phi wrap modulus.
REQ-005 clk  in  1  single clock; all state is updated on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 numtowers  in  11  number of valid towers; sampled when a seed is accepted.
REQ-008 frame_start  in  1  one-cycle pulse marking a new event.
REQ-009 seed_valid, seed_ready  in/out  1 each  seed stream handshake.
REQ-010 seed_eta, seed_phi, seed_et, seed_e  in  W each  seed tower from the seed selector.
REQ-011 twr_addr  out  10  tower memory read address.
REQ-012 twr_eta, twr_phi, twr_et, twr_e  in  W each  tower data, valid exactly one cycle after twr_addr.
REQ-013 jet_valid, jet_ready  out/in  1 each  jet stream handshake.
REQ-014 jet_eta, jet_phi  out  W each  seed position.
REQ-015 jet_et, jet_e  out  2W each  summed tower Et and E.
REQ-016 jet_ntowers  out  11  number of towers summed.

Function
REQ-017 The FSM SHALL have four states: IDLE, SCAN, DRAIN and EMIT.
REQ-018 seed_ready SHALL be 1 only in IDLE; a seed is accepted when seed_valid and seed_ready are both 1.
REQ-019 An accepted seed with seed_et==0 SHALL be discarded, and the FSM stays in IDLE.
REQ-020 An accepted seed with nonzero Et SHALL latch the seed fields and numtowers, clear the accumulators, and move to SCAN.
REQ-021 SCAN SHALL issue twr_addr = 0,1,...,numtowers-1, one address per cycle, then move to DRAIN for one cycle and then to EMIT.
REQ-022 With numtowers==0, the FSM SHALL go directly from SCAN to EMIT, with zero sums and jet_ntowers=0.
REQ-023 Each returned tower SHALL be evaluated one cycle after its address: deta=|seed_eta-twr_eta|; dphi=|seed_phi-twr_phi|; if dphi>31 then dphi=PHI_PERIOD-dphi.
REQ-024 dR2 = deta*deta + dphi*dphi SHALL be computed at 2W+1 bits with no truncation.
REQ-025 A tower SHALL be summed iff dR2<RADIUS2 (strict) and twr_et!=0.
REQ-026 When a tower is summed, jet_et += twr_et, jet_e += twr_e and jet_ntowers += 1; 2W-bit sums cannot overflow for MAX_TOWERS<=1024.
REQ-027 The seed tower itself (dR2=0) SHALL be summed.
REQ-028 In EMIT, jet_valid=1 and all jet_* outputs SHALL be held stable until jet_ready=1.
REQ-029 On the jet_valid&&jet_ready cycle, the FSM SHALL return to IDLE.
REQ-030 Latency: seed accepted at cycle 0 -> first address at cycle 1 -> jet_valid rises at cycle numtowers+2.
REQ-031 A frame_start asserted outside IDLE SHALL abort the current seed: return to IDLE with no jet emitted.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE, and seed_ready=0, jet_valid=0, and twr_addr and all jet_* outputs SHALL be 0.
REQ-033 seed_ready SHALL rise on the first clock edge after rst deasserts.
REQ-034 rst asserted mid-SCAN or mid-EMIT SHALL drop the in-flight jet immediately.

Configuration
REQ-035 Macro JET_BUILDER_EXCLUSIVE_EN defined: the block SHALL keep a MAX_TOWERS-bit used vector.
REQ-036 With the macro defined, a summed tower SHALL set its used bit, and a tower whose used bit is set SHALL NOT be summed again.
REQ-037 With the macro defined, the used vector SHALL be cleared by rst and by frame_start.
REQ-038 Macro JET_BUILDER_EXCLUSIVE_EN undefined: there SHALL be no used vector, and a tower may contribute to several jets.

Structure
REQ-039 Package jet_pkg SHALL hold W, RADIUS2, PHI_PERIOD, a tower_t struct {eta, phi, et, e} and an FSM state enum.
REQ-040 Sub-module jet_dr2 SHALL be a combinational block: seed eta/phi and tower eta/phi in, dR2 out, including the phi wrap; it is shared with the seed selector.

Verification
REQ-041 Seed (eta 10, phi 10, et 50); numtowers 3; towers (10,10,50), (15,12,20), (30,10,40) -> jet_et=70, jet_ntowers=2, jet_valid at cycle 5.
REQ-042 Seed phi 1; tower phi 60, eta equal, et 8 -> dphi=3, tower summed (wrap-around).
REQ-043 Seed et 0 -> seed_ready stays 1, no jet, twr_addr never advances.
REQ-044 jet_ready held 0 for 10 cycles -> jet fields stable, seed_ready=0, then one transfer.
REQ-045 EXCLUSIVE_EN: two identical seeds -> second jet has jet_ntowers=0; after frame_start, full sum again.
REQ-046 rst pulse at SCAN cycle 2 -> outputs 0 at once, no jet_valid, next seed processed normally.
